rail_switch_seq: RTL and testbench

RAIL_SWITCH_SEQ -- requirements
Module: rail_switch_seq

---
 rtl/rail_switch_seq.sv | 153 +++++++++++++++
 tb/tb_rail_switch_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rail_switch_seq.sv
// Power-gating rail switch sequencer: ramps switch banks on and off one step at a time, then waits for rail-good.
// Optional ON-state rail monitor enabled by defining RAIL_SWITCH_SEQ_MON_EN.
module rail_switch_seq #(
  parameter int NBANK       = 8,
  parameter int STEP_CYC    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWR_REQ,
  input  logic             RAIL_OK,
  output logic [NBANK-1:0] SW,
  output logic             PWR_ACK,
  output logic             BUSY,
  output logic             FAULT
);

  localparam int TMAX = (STEP_CYC > TIMEOUT_CYC) ? STEP_CYC : TIMEOUT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] STEP_LAST    = TW'(STEP_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF, S_RAMP_UP, S_SETTLE, S_ON, S_RAMP_DN, S_FLT
  } state_t;

  state_t           r_state, w_stateNxt;
  logic [NBANK-1:0] r_sw, w_swNxt;
  logic [TW-1:0]    r_timer, w_timerNxt;
  logic             r_sync1, r_sync2;
  logic             r_ack, r_busy, r_fault;
  logic             w_ackNxt, w_busyNxt, w_faultNxt;
  logic             w_railOk;
  logic             w_stepDone;

  assign w_railOk   = r_sync2;
  assign w_stepDone = (r_timer == STEP_LAST);

`ifdef RAIL_SWITCH_SEQ_MON_EN
  logic r_monLow;

  always_ff @(posedge CLK) begin
    if (RST) r_monLow <= 1'b0;
    else     r_monLow <= (r_state == S_ON) && !w_railOk;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_OFF;
      r_sw    <= '0;
      r_timer <= '0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_sw    <= w_swNxt;
      r_timer <= w_timerNxt;
      r_sync1 <= RAIL_OK;
      r_sync2 <= r_sync1;
      r_ack   <= w_ackNxt;
      r_busy  <= w_busyNxt;
      r_fault <= w_faultNxt;
    end
  end

  // A PWR_REQ direction change is tested before timer expiry so it always wins.
  always_comb begin
    w_stateNxt = r_state;
    w_swNxt    = r_sw;
    w_timerNxt = r_timer + 1'b1;
    unique case (r_state)
      S_OFF: begin
        w_timerNxt = '0;
        if (PWR_REQ) begin
          w_stateNxt = S_RAMP_UP;
          w_swNxt    = NBANK'(1);
        end
      end
      S_RAMP_UP: begin
        if (!PWR_REQ) begin
          w_stateNxt = S_RAMP_DN;
          w_timerNxt = '0;
        end else if (w_stepDone) begin
          w_timerNxt = '0;
          if (&r_sw) w_stateNxt = S_SETTLE;
          else       w_swNxt    = r_sw | (r_sw + NBANK'(1));
        end
      end
      S_SETTLE: begin
        if (!PWR_REQ) begin
          w_stateNxt = S_RAMP_DN;
          w_timerNxt = '0;
        end else if (w_railOk) begin
          w_stateNxt = S_ON;
          w_timerNxt = '0;
        end else if (r_timer == TIMEOUT_LAST) begin
          w_stateNxt = S_FLT;
          w_swNxt    = '0;
          w_timerNxt = '0;
        end
      end
      S_ON: begin
        w_timerNxt = '0;
        if (!PWR_REQ) begin
          w_stateNxt = S_RAMP_DN;
        end
`ifdef RAIL_SWITCH_SEQ_MON_EN
        else if (!w_railOk && r_monLow) begin
          w_stateNxt = S_FLT;
          w_swNxt    = '0;
        end
`endif
      end
      S_RAMP_DN: begin
        if (PWR_REQ) begin
          w_stateNxt = S_RAMP_UP;
          w_timerNxt = '0;
        end else if (w_stepDone) begin
          w_timerNxt = '0;
          w_swNxt    = r_sw >> 1;
          if ((r_sw >> 1) == '0) w_stateNxt = S_OFF;
        end
      end
      S_FLT: begin
        w_swNxt    = '0;
        w_timerNxt = '0;
        if (!PWR_REQ) w_stateNxt = S_OFF;
      end
      default: begin
        w_stateNxt = S_OFF;
        w_swNxt    = '0;
        w_timerNxt = '0;
      end
    endcase
  end

  always_comb begin
    w_ackNxt   = (w_stateNxt == S_ON);
    w_busyNxt  = (w_stateNxt == S_RAMP_UP) || (w_stateNxt == S_SETTLE) ||
                 (w_stateNxt == S_RAMP_DN);
    w_faultNxt = (w_stateNxt == S_FLT);
  end

  assign SW      = r_sw;
  assign PWR_ACK = r_ack;
  assign BUSY    = r_busy;
  assign FAULT   = r_fault;

endmodule

// File: tb/tb_rail_switch_seq.sv
// Randomized + directed bench for rail_switch_seq, checked against a bank-count reference model.
module tb_rail_switch_seq;
  localparam int NB   = 4;
  localparam int STEP = 2;
  localparam int TO   = 8;

  localparam int M_IDLE = 0, M_UP = 1, M_SETTLE = 2, M_ON = 3, M_DOWN = 4, M_FAULT = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          PWR_REQ = 1'b0;
  logic          RAIL_OK = 1'b0;
  logic [NB-1:0] SW;
  logic          PWR_ACK, BUSY, FAULT;

  int checks = 0;
  int failures = 0;

  int mMode = M_IDLE;
  int mBanks = 0;
  int mWait = 0;
  bit mOkHist1 = 0, mOkHist2 = 0;
  bit mLowPrev = 0;

  rail_switch_seq #(.NBANK(NB), .STEP_CYC(STEP), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .PWR_REQ(PWR_REQ), .RAIL_OK(RAIL_OK),
    .SW(SW), .PWR_ACK(PWR_ACK), .BUSY(BUSY), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference behaviour, in terms of "banks on" and "cycles waited".
  task automatic modelStep(input bit req, input bit ok, input bit rst);
    bit railGood;
    bit lowNow;
    if (rst) begin
      mMode = M_IDLE; mBanks = 0; mWait = 0;
      mOkHist1 = 0; mOkHist2 = 0; mLowPrev = 0;
      return;
    end
    railGood = mOkHist2;
    mOkHist2 = mOkHist1;
    mOkHist1 = ok;
    lowNow = (mMode == M_ON) && !railGood;
    case (mMode)
      M_IDLE: if (req) begin mMode = M_UP; mBanks = 1; mWait = 0; end
      M_UP: begin
        if (!req) begin mMode = M_DOWN; mWait = 0; end
        else if (mWait == STEP - 1) begin
          mWait = 0;
          if (mBanks == NB) mMode = M_SETTLE;
          else mBanks++;
        end else mWait++;
      end
      M_SETTLE: begin
        if (!req) begin mMode = M_DOWN; mWait = 0; end
        else if (railGood) mMode = M_ON;
        else if (mWait == TO - 1) begin mMode = M_FAULT; mBanks = 0; end
        else mWait++;
      end
      M_ON: begin
        if (!req) begin mMode = M_DOWN; mWait = 0; end
`ifdef RAIL_SWITCH_SEQ_MON_EN
        else if (!railGood && mLowPrev) begin mMode = M_FAULT; mBanks = 0; end
`endif
      end
      M_DOWN: begin
        if (req) begin mMode = M_UP; mWait = 0; end
        else if (mWait == STEP - 1) begin
          mWait = 0;
          mBanks--;
          if (mBanks == 0) mMode = M_IDLE;
        end else mWait++;
      end
      default: begin
        mBanks = 0;
        if (!req) mMode = M_IDLE;
      end
    endcase
    mLowPrev = lowNow;
  endtask

  task automatic applyStimulus(input bit req, input bit ok, input bit rst);
    PWR_REQ = req;
    RAIL_OK = ok;
    RST = rst;
    @(posedge CLK);
    modelStep(req, ok, rst);
    #1;
    checkOutput("sw", 32'(SW), (32'd1 << mBanks) - 32'd1);
    checkOutput("ack", 32'(PWR_ACK), 32'(mMode == M_ON));
    checkOutput("busy", 32'(BUSY), 32'(mMode == M_UP || mMode == M_SETTLE || mMode == M_DOWN));
    checkOutput("fault", 32'(FAULT), 32'(mMode == M_FAULT));
  endtask

  initial begin
    int holdReq, holdOk;
    bit req, ok;

    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("rst_sw", 32'(SW), 32'h0);
    checkOutput("rst_flags", {29'b0, PWR_ACK, BUSY, FAULT}, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);

    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1, 1, 0);
      if (e == 1) checkOutput("up_e1", 32'(SW), 32'h1);
      if (e == 3) checkOutput("up_e3", 32'(SW), 32'h3);
      if (e == 7) checkOutput("up_e7", 32'(SW), 32'hF);
      if (e == 9) checkOutput("up_settle_busy", 32'(BUSY), 32'h1);
      if (e == 10) checkOutput("up_ack_busy", {30'b0, PWR_ACK, BUSY}, 32'h2);
    end

    for (int k = 0; k <= 8; k++) begin
      applyStimulus(0, 1, 0);
      if (k == 0) checkOutput("dn_ack", 32'(PWR_ACK), 32'h0);
      if (k == 2) checkOutput("dn_m2", 32'(SW), 32'h7);
      if (k == 6) checkOutput("dn_m6", 32'(SW), 32'h1);
      if (k == 8) checkOutput("dn_off", {28'b0, SW}, 32'h0);
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
    for (int e = 1; e <= 17; e++) begin
      applyStimulus(1, 0, 0);
      if (e == 16) checkOutput("to_e16_fault", 32'(FAULT), 32'h0);
      if (e == 17) checkOutput("to_e17", {27'b0, FAULT, SW}, 32'h10);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0);
    checkOutput("to_sticky", 32'(FAULT), 32'h1);
    applyStimulus(0, 1, 0);
    checkOutput("to_clear", 32'(FAULT), 32'h0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0);
    for (int e = 1; e <= 9; e++) begin
      applyStimulus((e <= 3 || e >= 7), 1, 0);
      if (e == 5) checkOutput("rev_hold", 32'(SW), 32'h3);
      if (e == 6) checkOutput("rev_down", 32'(SW), 32'h1);
      if (e == 9) checkOutput("rev_up", 32'(SW), 32'h3);
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);

    for (int e = 1; e <= 5; e++) applyStimulus(1, 1, 0);
    checkOutput("rst_mid_pre", 32'(SW), 32'h7);
    applyStimulus(1, 1, 1);
    checkOutput("rst_mid_all", {28'b0, SW} | {29'b0, PWR_ACK, BUSY, FAULT}, 32'h0);
    applyStimulus(1, 1, 0);
    checkOutput("rst_restart", 32'(SW), 32'h1);
    for (int e = 0; e < 12; e++) applyStimulus(1, 1, 0);
    checkOutput("mon_pre_ack", 32'(PWR_ACK), 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 0);
`ifdef RAIL_SWITCH_SEQ_MON_EN
    checkOutput("mon_fault", {27'b0, FAULT, SW}, 32'h10);
`else
    checkOutput("mon_ignored", {27'b0, PWR_ACK, SW}, 32'h1F);
`endif
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0);

    holdReq = 0;
    holdOk = 0;
    req = 0;
    ok = 1;
    for (int c = 0; c < 4000; c++) begin
      if (holdReq == 0) begin
        req = ~req;
        holdReq = (($urandom % 4) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
      end
      if (holdOk == 0) begin
        ok = ($urandom % 4) != 0;
        holdOk = $urandom_range(1, 25);
      end
      holdReq--;
      holdOk--;
      applyStimulus(req, ok, ($urandom % 300) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
